// File: rtl/asm_line_scanner.sv
// asm_line_scanner: filters a raw ASCII source stream into printable characters
// and end-of-line events, strips '#' comments and counts lines.
// Optional feature macro: ASM_SCANNER_LOWERCASE_EN folds 'A'-'Z' to 'a'-'z'.
module asm_line_scanner #(
  parameter int unsigned NUMBER_LINES = 256
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            char_valid_in,
  input  logic [7:0]                      char_in,
  output logic                            char_ready_out,
  output logic                            new_character,
  output logic                            new_line,
  output logic [7:0]                      ascii_out,
  output logic [$clog2(NUMBER_LINES)-1:0] line_num_out,
  output logic                            line_overflow_out,
  output logic                            done_out
);

  localparam int unsigned LW = $clog2(NUMBER_LINES);
  localparam logic [LW-1:0] LINE_MAX = LW'(NUMBER_LINES - 1);

  typedef enum logic [1:0] {
    S_LINE,
    S_COMMENT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          ready_q;
  logic          new_char_q;
  logic          new_line_q;
  logic [7:0]    ascii_q;
  logic [LW-1:0] line_q;
  logic          ovf_q;
  logic          done_q;
  logic          content_q;

  logic          accept;
  logic          is_lf;
  logic          is_term;
  logic          is_hash;
  logic          is_tab;
  logic          is_print;
  logic          line_wrap;
  logic [LW-1:0] line_d;

  // Character mapping applied to every emitted printable character
  function automatic logic [7:0] map_char(input logic [7:0] c);
`ifdef ASM_SCANNER_LOWERCASE_EN
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
    return c;
  endfunction

  // Ready is a registered state decode, forced low while reset is asserted
  assign char_ready_out = ready_q & ~rst_in;
  assign accept         = char_valid_in & char_ready_out;

  // Character classification of the offered byte
  assign is_lf    = (char_in == 8'h0A);
  assign is_term  = (char_in == 8'h00) || (char_in == 8'h04);
  assign is_hash  = (char_in == 8'h23);
  assign is_tab   = (char_in == 8'h09);
  assign is_print = (char_in >= 8'h20) && (char_in <= 8'h7E);

  // Next line number with explicit wrap at NUMBER_LINES-1
  assign line_wrap = (line_q == LINE_MAX);
  assign line_d    = line_wrap ? '0 : line_q + LW'(1);

  // Scanner FSM with registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_LINE;
      ready_q    <= 1'b1;
      new_char_q <= 1'b0;
      new_line_q <= 1'b0;
      ascii_q    <= 8'h00;
      line_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      content_q  <= 1'b0;
    end else begin
      new_char_q <= 1'b0;
      new_line_q <= 1'b0;
      case (state_q)
        S_LINE, S_COMMENT: begin
          if (accept) begin
            if (is_lf) begin
              new_line_q <= 1'b1;
              line_q     <= line_d;
              if (line_wrap) ovf_q <= 1'b1;
              content_q  <= 1'b0;
              state_q    <= S_LINE;
            end else if (is_term) begin
              ready_q <= 1'b0;
              state_q <= content_q ? S_FLUSH : S_DONE;
            end else if (state_q == S_LINE) begin
              if (is_hash) begin
                state_q <= S_COMMENT;
              end else if (is_tab) begin
                new_char_q <= 1'b1;
                ascii_q    <= 8'h20;
              end else if (is_print) begin
                new_char_q <= 1'b1;
                ascii_q    <= map_char(char_in);
                if (char_in != 8'h20) content_q <= 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          new_line_q <= 1'b1;
          line_q     <= line_d;
          if (line_wrap) ovf_q <= 1'b1;
          content_q  <= 1'b0;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
        end
      endcase
    end
  end

  assign new_character     = new_char_q;
  assign new_line          = new_line_q;
  assign ascii_out         = ascii_q;
  assign line_num_out      = line_q;
  assign line_overflow_out = ovf_q;
  assign done_out          = done_q;

endmodule

// File: tb/tb_asm_line_scanner.sv
// Self-checking bench for asm_line_scanner (NUMBER_LINES=4 so wrap is reachable).
module tb_asm_line_scanner;

  localparam int unsigned NL = 4;
  localparam int unsigned LW = $clog2(NL);
  localparam int K_NONE  = 0;
  localparam int K_CHAR  = 1;
  localparam int K_LINE  = 2;
  localparam int K_FLUSH = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          char_valid_in;
  logic [7:0]    char_in;
  logic          char_ready_out;
  logic          new_character;
  logic          new_line;
  logic [7:0]    ascii_out;
  logic [LW-1:0] line_num_out;
  logic          line_overflow_out;
  logic          done_out;

  asm_line_scanner #(.NUMBER_LINES(NL)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .char_valid_in     (char_valid_in),
    .char_in           (char_in),
    .char_ready_out    (char_ready_out),
    .new_character     (new_character),
    .new_line          (new_line),
    .ascii_out         (ascii_out),
    .line_num_out      (line_num_out),
    .line_overflow_out (line_overflow_out),
    .done_out          (done_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ch;
    int         kind;
    logic [7:0] asc;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] asc;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  vec_t tbl_add[7];
  vec_t tbl_cmt[9];
  vec_t tbl_misc[7];

  function automatic logic [7:0] lc(input logic [7:0] c);
`ifdef ASM_SCANNER_LOWERCASE_EN
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Offer one character for exactly one clock edge and log its expected pulse
  task automatic send(input logic [7:0] ch, input int kind, input logic [7:0] asc);
    exp_t e;
    @(negedge clk_in);
    #1;
    char_valid_in = 1'b1;
    char_in       = ch;
    check("ready_on_offer", 32'(char_ready_out), 32'd1);
    if (kind == K_CHAR || kind == K_LINE) begin
      e.kind = kind; e.asc = asc; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end else if (kind == K_FLUSH) begin
      e.kind = K_LINE; e.asc = 8'h00; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk_in);
    #1;
    char_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in        = 1'b1;
    char_valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk_in);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Output monitor: every pulse must match the oldest expected event
  always @(negedge clk_in) begin
    exp_t e;
    if (new_character && new_line)
      check("pulse_overlap", 32'd1, 32'd0);
    if (new_character || new_line) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, new_line, new_character}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", new_line ? 32'(K_LINE) : 32'(K_CHAR), 32'(e.kind));
        if (new_character) check("ascii_out", 32'(ascii_out), 32'(e.asc));
        check("pulse_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int exp_line;
    tbl_add = '{'{8'h61, K_CHAR, 8'h61}, '{8'h64, K_CHAR, 8'h64}, '{8'h64, K_CHAR, 8'h64},
                '{8'h20, K_CHAR, 8'h20}, '{8'h78, K_CHAR, 8'h78}, '{8'h31, K_CHAR, 8'h31},
                '{8'h0A, K_LINE, 8'h00}};
    tbl_cmt = '{'{8'h6C, K_CHAR, 8'h6C}, '{8'h69, K_CHAR, 8'h69}, '{8'h20, K_CHAR, 8'h20},
                '{8'h23, K_NONE, 8'h00}, '{8'h63, K_NONE, 8'h00}, '{8'h6D, K_NONE, 8'h00},
                '{8'h74, K_NONE, 8'h00}, '{8'h0D, K_NONE, 8'h00}, '{8'h0A, K_LINE, 8'h00}};
    tbl_misc = '{'{8'h09, K_CHAR, 8'h20}, '{8'h7E, K_CHAR, 8'h7E}, '{8'h7F, K_NONE, 8'h00},
                 '{8'h01, K_NONE, 8'h00}, '{8'h5A, K_CHAR, lc(8'h5A)},
                 '{8'h20, K_CHAR, 8'h20}, '{8'h0A, K_LINE, 8'h00}};

    // Reset with a character offered: nothing accepted, all outputs at reset values
    rst_in = 1'b1; char_valid_in = 1'b1; char_in = 8'h78;
    repeat (2) @(negedge clk_in);
    check("rst_ready",    32'(char_ready_out),    32'd0);
    check("rst_new_char", 32'(new_character),     32'd0);
    check("rst_new_line", 32'(new_line),          32'd0);
    check("rst_ascii",    32'(ascii_out),         32'd0);
    check("rst_line_num", 32'(line_num_out),      32'd0);
    check("rst_overflow", 32'(line_overflow_out), 32'd0);
    check("rst_done",     32'(done_out),          32'd0);
    rst_in = 1'b0; char_valid_in = 1'b0;
    #1;
    check("ready_after_rst", 32'(char_ready_out), 32'd1);

    // "add x1\n"
    foreach (tbl_add[i]) send(tbl_add[i].ch, tbl_add[i].kind, tbl_add[i].asc);
    check("add_line_num", 32'(line_num_out), 32'd1);
    drain();

    // "li #cmt\r\n" then tab / tilde / DEL / ctrl / letter / space line
    do_reset();
    foreach (tbl_cmt[i]) send(tbl_cmt[i].ch, tbl_cmt[i].kind, tbl_cmt[i].asc);
    check("cmt_line_num", 32'(line_num_out), 32'd1);
    foreach (tbl_misc[i]) send(tbl_misc[i].ch, tbl_misc[i].kind, tbl_misc[i].asc);
    check("misc_line_num", 32'(line_num_out), 32'd2);
    drain();

    // "nop" + EOT: flush line, then done, then no more acceptance
    do_reset();
    send(8'h6E, K_CHAR, 8'h6E);
    send(8'h6F, K_CHAR, 8'h6F);
    send(8'h70, K_CHAR, 8'h70);
    send(8'h04, K_FLUSH, 8'h00);
    check("flush_ready", 32'(char_ready_out), 32'd0);
    check("flush_done0", 32'(done_out), 32'd0);
    @(posedge clk_in); #1;
    check("flush_line_num", 32'(line_num_out), 32'd1);
    check("flush_done1", 32'(done_out), 32'd0);
    @(posedge clk_in); #1;
    check("done_set", 32'(done_out), 32'd1);
    char_valid_in = 1'b1; char_in = 8'h71;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("done_ready", 32'(char_ready_out), 32'd0);
    end
    char_valid_in = 1'b0;
    drain();
    check("done_held", 32'(done_out), 32'd1);
    check("done_line_num", 32'(line_num_out), 32'd1);

    // "\n" then NUL: empty line, terminator goes straight to done
    do_reset();
    send(8'h0A, K_LINE, 8'h00);
    send(8'h00, K_NONE, 8'h00);
    check("nul_ready", 32'(char_ready_out), 32'd0);
    @(posedge clk_in); #1;
    check("nul_done", 32'(done_out), 32'd1);
    check("nul_line_num", 32'(line_num_out), 32'd1);
    drain();

    // Space-only line does not count as content
    do_reset();
    send(8'h20, K_CHAR, 8'h20);
    send(8'h04, K_NONE, 8'h00);
    @(posedge clk_in); #1;
    check("space_done", 32'(done_out), 32'd1);
    check("space_line_num", 32'(line_num_out), 32'd0);
    drain();

    // Line counter wrap and sticky overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h0A, K_LINE, 8'h00);
      exp_line = (i + 1) % 4;
      check("wrap_line_num", 32'(line_num_out), 32'(exp_line));
      check("wrap_overflow", 32'(line_overflow_out), (i >= 3) ? 32'd1 : 32'd0);
    end
    drain();

    // Reset mid-line with valid held
    do_reset();
    send(8'h61, K_CHAR, 8'h61);
    send(8'h64, K_CHAR, 8'h64);
    rst_in = 1'b1; char_valid_in = 1'b1; char_in = 8'h64;
    #1;
    check("mid_rst_ready", 32'(char_ready_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in); #1;
      check("mid_rst_new_char", 32'(new_character), 32'd0);
      check("mid_rst_new_line", 32'(new_line),      32'd0);
      check("mid_rst_ascii",    32'(ascii_out),     32'd0);
      check("mid_rst_line_num", 32'(line_num_out),  32'd0);
      check("mid_rst_done",     32'(done_out),      32'd0);
    end
    @(negedge clk_in);
    rst_in = 1'b0; char_valid_in = 1'b0;

    // "ADD\n": letters folded only when the lowercase option is built in
    send(8'h41, K_CHAR, lc(8'h41));
    send(8'h44, K_CHAR, lc(8'h44));
    send(8'h44, K_CHAR, lc(8'h44));
    send(8'h0A, K_LINE, 8'h00);
    check("upper_line_num", 32'(line_num_out), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
